// File: rtl/sc_cpu_pkg.sv
// Shared definitions for the single-cycle MIPS-32 subset core:
// opcode/funct encodings and the ALU operation enum.
package sc_cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    typedef enum logic [3:0] {
        ADD, SUB, AND, OR, XOR, LUI, SLL, SRL, SRA
    } alu_op_t;

endpackage

// File: rtl/sc_regfile.sv
// 32x32 register file: two combinational reads, one write per clock.
// r0 is hardwired to zero; reads see the value before this edge's write.
module sc_regfile (
    input  logic        clock,
    input  logic        resetn,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [32];

    always_ff @(posedge clock) begin
        if (resetn) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];

endmodule

// File: rtl/sc_cpu_core.sv
// Single-cycle MIPS-32 subset core: decode, ALU, next-PC and writeback
// select are inline; only the register file is a separate block.
module sc_cpu_core
    import sc_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] inst,
    input  logic [31:0] memout,
    output logic [31:0] pc,
    output logic        wmem,
    output logic [31:0] aluout,
    output logic [31:0] data
);

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] addr;

    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign shamt = inst[10:6];
    assign funct = inst[5:0];
    assign imm   = inst[15:0];
    assign addr  = inst[25:0];

    alu_op_t     alu_op;
    logic        use_imm, imm_zext, wreg, dest_rd;
    logic        is_load, is_store, is_jal, is_jump, is_jr;
    logic        is_beq, is_bne;
    logic [31:0] qa, qb, opb, pc4, npc, wd;
    logic [31:0] sext, zext;
    logic [4:0]  wa;
    logic        taken;

    always_comb begin
        alu_op   = ADD;
        use_imm  = 1'b0;
        imm_zext = 1'b0;
        wreg     = 1'b0;
        dest_rd  = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_jal   = 1'b0;
        is_jump  = 1'b0;
        is_jr    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        case (op)
            OP_RTYPE: begin
                dest_rd = 1'b1;
                wreg    = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ADD;
                    FN_SUB:  alu_op = SUB;
                    FN_AND:  alu_op = AND;
                    FN_OR:   alu_op = OR;
                    FN_XOR:  alu_op = XOR;
                    FN_SLL:  alu_op = SLL;
                    FN_SRL:  alu_op = SRL;
                    FN_SRA:  alu_op = SRA;
                    FN_JR: begin
                        wreg  = 1'b0;
                        is_jr = 1'b1;
                    end
                    default: wreg = 1'b0;
                endcase
            end
            OP_ADDI: begin
                use_imm = 1'b1;
                wreg    = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                use_imm  = 1'b1;
                imm_zext = 1'b1;
                wreg     = 1'b1;
                alu_op   = (op == OP_ANDI) ? AND :
                           (op == OP_ORI)  ? OR  : XOR;
            end
            OP_LUI: begin
                alu_op = LUI;
                wreg   = 1'b1;
            end
            OP_LW: begin
                use_imm = 1'b1;
                wreg    = 1'b1;
                is_load = 1'b1;
            end
            OP_SW: begin
                use_imm  = 1'b1;
                is_store = 1'b1;
            end
            OP_BEQ: begin
                alu_op = SUB;
                is_beq = 1'b1;
            end
            OP_BNE: begin
                alu_op = SUB;
                is_bne = 1'b1;
            end
            OP_J:   is_jump = 1'b1;
            OP_JAL: begin
                is_jump = 1'b1;
                is_jal  = 1'b1;
                wreg    = 1'b1;
            end
            default: ;
        endcase
    end

    sc_regfile u_rf (
        .clock  (clock),
        .resetn (resetn),
        .we     (wreg & ~resetn),
        .wa     (wa),
        .wd     (wd),
        .ra1    (rs),
        .ra2    (rt),
        .rd1    (qa),
        .rd2    (qb)
    );

    assign sext = {{16{imm[15]}}, imm};
    assign zext = {16'h0, imm};
    assign opb  = use_imm ? (imm_zext ? zext : sext) : qb;

    always_comb begin
        aluout = qa + opb;
        case (alu_op)
            ADD: aluout = qa + opb;
            SUB: aluout = qa - opb;
            AND: aluout = qa & opb;
            OR:  aluout = qa | opb;
            XOR: aluout = qa ^ opb;
            LUI: aluout = {imm, 16'h0};
            SLL: aluout = qb << shamt;
            SRL: aluout = qb >> shamt;
            SRA: aluout = $signed(qb) >>> shamt;
            default: aluout = qa + opb;
        endcase
    end

    assign pc4   = pc + 32'd4;
    assign taken = (is_beq && qa == qb) || (is_bne && qa != qb);
    assign npc   = is_jr   ? qa :
                   is_jump ? {pc4[31:28], addr, 2'b00} :
                   taken   ? pc4 + {sext[29:0], 2'b00} : pc4;

    assign wa   = is_jal ? 5'd31 : (dest_rd ? rd : rt);
    assign wd   = is_jal ? pc4 : (is_load ? memout : aluout);
    assign wmem = is_store & ~resetn;
    assign data = qb;

    always_ff @(posedge clock) begin
        if (resetn) pc <= RESET_PC;
        else        pc <= npc;
    end

endmodule

// File: tb/tb_sc_cpu_core.sv
// Directed bench for sc_cpu_core: a table of hand-computed instruction
// vectors plus hand-written reset sequences.
module tb_sc_cpu_core;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] inst;
    logic [31:0] memout;
    logic [31:0] pc;
    logic        wmem;
    logic [31:0] aluout;
    logic [31:0] data;

    int n_tests = 0;
    int n_fail  = 0;

    sc_cpu_core dut (
        .clock  (clock),
        .resetn (resetn),
        .inst   (inst),
        .memout (memout),
        .pc     (pc),
        .wmem   (wmem),
        .aluout (aluout),
        .data   (data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] memout;
        logic        wmem;
        logic [31:0] alu;
        logic        ca;
        logic [31:0] data;
        logic        cd;
        logic [31:0] npc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] i, input logic [31:0] m,
                       input logic w, input logic [31:0] a,
                       input logic ca, input logic [31:0] d,
                       input logic cd, input logic [31:0] n);
        vec_t v;
        v.inst = i; v.memout = m; v.wmem = w; v.alu = a;
        v.ca = ca; v.data = d; v.cd = cd; v.npc = n;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        resetn = 1'b1;
        inst   = 32'hAC01_0008;
        memout = 32'h0;

        // reset: wmem forced low even with a store on inst
        #1 chk("rst_wmem_comb", {31'h0, wmem}, 32'h0);
        @(posedge clock);
        @(posedge clock); #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_wmem", {31'h0, wmem}, 32'h0);
        resetn = 1'b0;
        inst   = 32'h0;
        #1 chk("first_fetch", pc, 32'h0);
        @(posedge clock); #1 chk("nop_pc4", pc, 32'h4);
        @(posedge clock); #1 chk("nop_pc8", pc, 32'h8);

        resetn = 1'b1;
        @(posedge clock); #1;
        resetn = 1'b0;
        chk("rerst_pc", pc, 32'h0);

        add(32'h2001_7FFF, 0, 0, 32'h0000_7FFF, 1, 32'h0, 1, 32'h04);
        add(32'h3C02_8000, 0, 0, 32'h8000_0000, 1, 32'h0, 1, 32'h08);
        add(32'h0022_1820, 0, 0, 32'h8000_7FFF, 1, 32'h8000_0000, 1, 32'h0C);
        add(32'h0002_2103, 0, 0, 32'hF800_0000, 1, 32'h0, 0, 32'h10);
        add(32'h0001_2822, 0, 0, 32'hFFFF_8001, 1, 32'h7FFF, 1, 32'h14);
        add(32'hAC01_0008, 0, 1, 32'h8, 1, 32'h7FFF, 1, 32'h18);
        add(32'h8C06_0008, 32'h1234, 0, 32'h8, 1, 32'h0, 1, 32'h1C);
        add(32'hAC06_000C, 0, 1, 32'hC, 1, 32'h1234, 1, 32'h20);
        add(32'h0C00_0040, 0, 0, 32'h0, 0, 32'h0, 0, 32'h100);
        add(32'h03E0_0008, 0, 0, 32'h0, 0, 32'h0, 0, 32'h24);
        add(32'h0800_0004, 0, 0, 32'h0, 0, 32'h0, 0, 32'h10);
        add(32'h1000_FFFE, 0, 0, 32'h0, 1, 32'h0, 1, 32'h0C);
        add(32'h0800_0004, 0, 0, 32'h0, 0, 32'h0, 0, 32'h10);
        add(32'h1400_0005, 0, 0, 32'h0, 1, 32'h0, 1, 32'h14);
        add(32'h1420_0001, 0, 0, 32'h7FFF, 1, 32'h0, 1, 32'h1C);
        add(32'h2000_0005, 0, 0, 32'h5, 1, 32'h0, 0, 32'h20);
        add(32'h0000_3820, 0, 0, 32'h0, 1, 32'h0, 1, 32'h24);
        add(32'hFC01_FFFF, 0, 0, 32'h0, 0, 32'h0, 0, 32'h28);
        add(32'h0000_083F, 0, 0, 32'h0, 0, 32'h0, 0, 32'h2C);
        add(32'hAC01_0000, 0, 1, 32'h0, 1, 32'h7FFF, 1, 32'h30);
        add(32'h3428_8000, 0, 0, 32'h0000_FFFF, 1, 32'h0, 0, 32'h34);
        add(32'h3049_FFFF, 0, 0, 32'h0, 1, 32'h0, 0, 32'h38);
        add(32'h382A_FFFF, 0, 0, 32'h0000_8000, 1, 32'h0, 0, 32'h3C);
        add(32'h0062_5820, 0, 0, 32'h0000_7FFF, 1, 32'h0, 0, 32'h40);
        add(32'h0002_6102, 0, 0, 32'h0800_0000, 1, 32'h0, 0, 32'h44);
        add(32'h0023_6826, 0, 0, 32'h8000_0000, 1, 32'h0, 0, 32'h48);
        add(32'h0001_7400, 0, 0, 32'h7FFF_0000, 1, 32'h0, 0, 32'h4C);
        add(32'h0022_7825, 0, 0, 32'h8000_7FFF, 1, 32'h0, 0, 32'h50);
        add(32'h0061_8024, 0, 0, 32'h0000_7FFF, 1, 32'h0, 0, 32'h54);
        add(32'h2011_FFFF, 0, 0, 32'hFFFF_FFFF, 1, 32'h0, 0, 32'h58);

        for (int i = 0; i < vecs.size(); i++) begin
            inst   = vecs[i].inst;
            memout = vecs[i].memout;
            @(negedge clock);
            chk($sformatf("v%0d_wmem", i), {31'h0, wmem},
                {31'h0, vecs[i].wmem});
            if (vecs[i].ca)
                chk($sformatf("v%0d_alu", i), aluout, vecs[i].alu);
            if (vecs[i].cd)
                chk($sformatf("v%0d_data", i), data, vecs[i].data);
            @(posedge clock); #1;
            chk($sformatf("v%0d_npc", i), pc, vecs[i].npc);
        end

        // mid-program reset with a store and then a write pending
        memout = 32'h0;
        inst   = 32'hAC01_0000;
        resetn = 1'b1;
        #1 chk("midrst_wmem", {31'h0, wmem}, 32'h0);
        inst = 32'h2001_0055;
        @(posedge clock); #1;
        chk("midrst_pc", pc, 32'h0);
        resetn = 1'b0;
        inst   = 32'hAC01_0000;
        #1;
        chk("midrst_r1", data, 32'h0);
        chk("midrst_sw", {31'h0, wmem}, 32'h1);
        @(posedge clock); #1;
        chk("midrst_npc", pc, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
